dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 13 +
 rtl/dmem_arb_pick.sv | 32 +++
 rtl/dmem_arbiter.sv | 140 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
package dmem_arb_pkg;

   localparam int WORD_BYTES        = 8;
   localparam int DEFAULT_MEM_BYTES = 64;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Winner selection between the two requesters.
// Build option DMEM_ARB_RR_EN: round-robin using the caller's preference bit;
// otherwise fixed priority with r0 winning every conflict.
module dmem_arb_pick (
   input  logic req0,
   input  logic req1,
`ifdef DMEM_ARB_RR_EN
   input  logic prefer_r1,
`endif
   output logic gnt0,
   output logic gnt1
);

   // One-hot winner among the (already qualified) requests
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
`ifdef DMEM_ARB_RR_EN
      if (req0 && req1) begin
         gnt0 = ~prefer_r1;
         gnt1 = prefer_r1;
      end else begin
         gnt0 = req0;
         gnt1 = req1;
      end
`else
      gnt0 = req0;
      gnt1 = req1 & ~req0;
`endif
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a single-port 64-bit data memory.
// One access takes IDLE -> ACCESS -> DONE. Out-of-range accesses never reach
// the memory and complete with an error flag and zero load data.
// Build option DMEM_ARB_RR_EN selects round-robin arbitration (default: r0 priority).
//
// state  | meaning
// IDLE   | arbitrate; grant is combinational, request fields latched at the edge
// ACCESS | drive memory strobe for one cycle; load data captured at the edge
// DONE   | owner's rvalid pulse (err qualifies it)
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int MEM_BYTES = DEFAULT_MEM_BYTES
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        r0_req,
   input  logic        r0_we,
   input  logic [63:0] r0_addr,
   input  logic [63:0] r0_wdata,
   input  logic        r1_req,
   input  logic        r1_we,
   input  logic [63:0] r1_addr,
   input  logic [63:0] r1_wdata,
   output logic        r0_gnt,
   output logic        r0_rvalid,
   output logic [63:0] r0_rdata,
   output logic        r0_err,
   output logic        r1_gnt,
   output logic        r1_rvalid,
   output logic [63:0] r1_rdata,
   output logic        r1_err,
   output logic [63:0] mem_addr,
   output logic [63:0] write_data,
   output logic        mem_write,
   output logic        mem_read,
   input  logic [63:0] Read_data
);

   state_t      state, state_nxt;
   logic        arb_en, pick0, pick1, take;
   logic        owner_q, we_q;
   logic [63:0] addr_q, wdata_q, rdata0_q, rdata1_q;
   logic [64:0] last_byte;
   logic        range_err;

   // Reset gates arbitration so no grant can appear while reset_n is low
   assign arb_en = (state == IDLE) && reset_n;
   assign take   = pick0 | pick1;

   // Extra bit keeps address wrap-around visible as out of range
   assign last_byte = {1'b0, addr_q} + 65'(WORD_BYTES - 1);
   assign range_err = last_byte >= 65'(MEM_BYTES);

`ifdef DMEM_ARB_RR_EN
   logic prefer_r1_q;

   // Favour whichever requester was not granted most recently
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  prefer_r1_q <= 1'b0;
      else if (take) prefer_r1_q <= pick0;
   end
`endif

   dmem_arb_pick u_pick (
      .req0      (r0_req & arb_en),
      .req1      (r1_req & arb_en),
`ifdef DMEM_ARB_RR_EN
      .prefer_r1 (prefer_r1_q),
`endif
      .gnt0      (pick0),
      .gnt1      (pick1)
   );

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (take) state_nxt = ACCESS;
         ACCESS:  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      r0_gnt    = pick0;
      r1_gnt    = pick1;
      mem_read  = (state == ACCESS) && !we_q && !range_err;
      mem_write = (state == ACCESS) &&  we_q && !range_err;
      r0_rvalid = (state == DONE) && !owner_q;
      r1_rvalid = (state == DONE) &&  owner_q;
      r0_err    = r0_rvalid && range_err;
      r1_err    = r1_rvalid && range_err;
   end

   // Latch the winner's request; memory address/data hold until the next grant
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         owner_q <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (take) begin
         owner_q <= pick1;
         we_q    <= pick1 ? r1_we    : r0_we;
         addr_q  <= pick1 ? r1_addr  : r0_addr;
         wdata_q <= pick1 ? r1_wdata : r0_wdata;
      end
   end

   // Per-requester load data, updated only on that requester's completion
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else if (state == ACCESS) begin
         if (range_err) begin
            if (owner_q) rdata1_q <= '0;
            else         rdata0_q <= '0;
         end else if (!we_q) begin
            if (owner_q) rdata1_q <= Read_data;
            else         rdata0_q <= Read_data;
         end
      end
   end

   assign r0_rdata   = rdata0_q;
   assign r1_rdata   = rdata1_q;
   assign mem_addr   = addr_q;
   assign write_data = wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 64-byte little-endian memory model.
module tb_dmem_arbiter;

   logic        clk, reset_n;
   logic        r0_req, r0_we, r1_req, r1_we;
   logic [63:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
   logic        r0_gnt, r0_rvalid, r0_err, r1_gnt, r1_rvalid, r1_err;
   logic [63:0] r0_rdata, r1_rdata;
   logic [63:0] mem_addr, write_data, Read_data;
   logic        mem_write, mem_read;

   logic [7:0]  mem [0:63];
   logic [63:0] rd_ia, wr_ia;
   int          errors = 0;
   int          checks = 0;

   dmem_arbiter #(.MEM_BYTES(64)) dut (
      .clk(clk), .reset_n(reset_n),
      .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
      .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
      .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_err(r0_err),
      .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_err(r1_err),
      .mem_addr(mem_addr), .write_data(write_data), .mem_write(mem_write),
      .mem_read(mem_read), .Read_data(Read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      Read_data = '0;
      rd_ia = '0;
      for (int b = 0; b < 8; b++) begin
         rd_ia = mem_addr + 64'(b);
         if (rd_ia < 64) Read_data[8*b +: 8] = mem[rd_ia[5:0]];
      end
   end

   always @(posedge clk) begin
      if (mem_write === 1'b1) begin
         for (int b = 0; b < 8; b++) begin
            wr_ia = mem_addr + 64'(b);
            if (wr_ia < 64) mem[wr_ia[5:0]] = write_data[8*b +: 8];
         end
      end
   end

   function automatic logic [63:0] mem_word(input int a);
      logic [63:0] w;
      w = '0;
      for (int b = 0; b < 8; b++) w[8*b +: 8] = mem[a + b];
      return w;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int k, input logic req, input logic we,
                        input logic [63:0] addr, input logic [63:0] wdata);
      if (k == 0) begin
         r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = wdata;
      end else begin
         r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = wdata;
      end
   endtask

   // Entered one step after a rising edge with the arbiter in IDLE; returns likewise
   task automatic access(input int k, input logic we, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic exp_err,
                         input logic [63:0] exp_rdata);
      drive(k, 1'b1, we, addr, wdata);
      #1;
      chk($sformatf("r%0d_gnt@%h", k, addr), (k == 1) ? r1_gnt : r0_gnt, 64'd1);
      chk($sformatf("other_gnt@%h", addr), (k == 1) ? r0_gnt : r1_gnt, 64'd0);
      @(posedge clk); #1;
      drive(k, 1'b0, 1'b0, '0, '0);
      chk($sformatf("mem_read@%h", addr), mem_read, 64'(!exp_err && !we));
      chk($sformatf("mem_write@%h", addr), mem_write, 64'(!exp_err && we));
      if (!exp_err) chk($sformatf("mem_addr@%h", addr), mem_addr, addr);
      if (!exp_err && we) chk($sformatf("write_data@%h", addr), write_data, wdata);
      chk($sformatf("early_rvalid@%h", addr), (k == 1) ? r1_rvalid : r0_rvalid, 64'd0);
      @(posedge clk); #1;
      chk($sformatf("r%0d_rvalid@%h", k, addr), (k == 1) ? r1_rvalid : r0_rvalid, 64'd1);
      chk($sformatf("r%0d_err@%h", k, addr), (k == 1) ? r1_err : r0_err, 64'(exp_err));
      if (!we || exp_err)
         chk($sformatf("r%0d_rdata@%h", k, addr), (k == 1) ? r1_rdata : r0_rdata, exp_rdata);
      chk($sformatf("strobes_done@%h", addr), {mem_read, mem_write}, 64'd0);
      @(posedge clk); #1;
      chk($sformatf("rvalid_pulse@%h", addr), (k == 1) ? r1_rvalid : r0_rvalid, 64'd0);
   endtask

   initial begin
      int exp_k;
      for (int i = 0; i < 64; i++) mem[i] = 8'h00;
      mem[0]  = 8'h04;
      mem[63] = 8'hAA;
      reset_n = 1'b0;
      drive(0, 1'b1, 1'b0, 64'd0, 64'd0);
      drive(1, 1'b0, 1'b0, 64'd0, 64'd0);
      #2;
      chk("reset_gnt", {r1_gnt, r0_gnt}, 64'd0);
      chk("reset_rvalid", {r1_rvalid, r0_rvalid, r1_err, r0_err}, 64'd0);
      chk("reset_strobes", {mem_read, mem_write}, 64'd0);
      chk("reset_mem_addr", mem_addr, 64'd0);
      chk("reset_rdata", r0_rdata | r1_rdata | write_data, 64'd0);
      drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      access(0, 1'b0, 64'd0, 64'd0, 1'b0, 64'h4);
      access(1, 1'b1, 64'd16, 64'hDEADBEEF00000001, 1'b0, 64'd0);
      chk("mem_after_write", mem_word(16), 64'hDEADBEEF00000001);
      access(1, 1'b0, 64'd16, 64'd0, 1'b0, 64'hDEADBEEF00000001);
      access(0, 1'b0, 64'd17, 64'd0, 1'b0, 64'h00DEADBEEF000000);
      access(1, 1'b0, 64'd56, 64'd0, 1'b0, 64'hAA00000000000000);
      access(0, 1'b0, 64'd57, 64'd0, 1'b1, 64'd0);
      access(0, 1'b0, 64'hFFFFFFFFFFFFFFFC, 64'd0, 1'b1, 64'd0);
      access(1, 1'b1, 64'd60, 64'h1122334455667788, 1'b1, 64'd0);
      chk("mem_after_err_write", mem_word(56), 64'hAA00000000000000);

      // Both requesters read continuously; last grant before this went to r1
      drive(0, 1'b1, 1'b0, 64'd0, 64'd0);
      drive(1, 1'b1, 1'b0, 64'd16, 64'd0);
      for (int i = 0; i < 3; i++) begin
`ifdef DMEM_ARB_RR_EN
         exp_k = i % 2;
`else
         exp_k = 0;
`endif
         #1;
         chk($sformatf("conflict%0d_gnt", i), {r1_gnt, r0_gnt}, (exp_k == 1) ? 64'd2 : 64'd1);
         @(posedge clk); #1;
         chk($sformatf("conflict%0d_gnt_access", i), {r1_gnt, r0_gnt}, 64'd0);
         @(posedge clk); #1;
         chk($sformatf("conflict%0d_rvalid", i), {r1_rvalid, r0_rvalid},
             (exp_k == 1) ? 64'd2 : 64'd1);
         chk($sformatf("conflict%0d_gnt_done", i), {r1_gnt, r0_gnt}, 64'd0);
         chk($sformatf("conflict%0d_rdata", i), (exp_k == 1) ? r1_rdata : r0_rdata,
             (exp_k == 1) ? 64'hDEADBEEF00000001 : 64'h4);
         @(posedge clk);
      end
      #1;
      drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
      drive(1, 1'b0, 1'b0, 64'd0, 64'd0);
      #1;
      chk("idle_no_gnt", {r1_gnt, r0_gnt}, 64'd0);
      @(posedge clk); #1;
      chk("idle_no_strobe", {mem_read, mem_write}, 64'd0);

      // Reset in the middle of a write abandons it
      drive(0, 1'b1, 1'b1, 64'd8, 64'h55);
      #1;
      chk("rst_wr_gnt", r0_gnt, 64'd1);
      @(posedge clk); #1;
      chk("rst_wr_access", mem_write, 64'd1);
      reset_n = 1'b0;
      #1;
      chk("rst_wr_drop", mem_write, 64'd0);
      chk("rst_wr_addr_clear", mem_addr, 64'd0);
      drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
      @(posedge clk); #1;
      chk("rst_wr_mem_untouched", mem_word(8), 64'd0);
      chk("rst_wr_no_rvalid", {r1_rvalid, r0_rvalid}, 64'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_wr_no_rvalid_after", {r1_rvalid, r0_rvalid}, 64'd0);
      @(posedge clk); #1;
      chk("rst_wr_quiet", {mem_read, mem_write, r0_rvalid}, 64'd0);
      chk("rst_wr_mem_final", mem_word(8), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
